mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 valid_i  in  1  instruction present from EX/MEM; 0 = bubble.
REQ-004 RegWrite_i, VRegWrite_i, MemtoReg_i  in  1 each  writeback controls from EX/MEM.
REQ-005 MemRead_i, MemWrite_i  in  1 each  memory strobes, low-active.
REQ-006 vec_mem_i  in  1  1 = 8-lane vector access, 0 = scalar access.
REQ-007 alu_result_i  in  32  byte address / ALU result; word address = alu_result_i[13:2].
REQ-008 write_addr_i  in  5  destination register; write_data_i  in  32  scalar store data.
REQ-009 vec_i  in  256  vector store data, lane k = bits [32k+31:32k].
REQ-010 sram_q_i  in  32  SRAM read data, valid 1 cycle after read issue.
REQ-011 sram_addr_o  out  12  SRAM word address; sram_d_o  out  32  write data.
REQ-012 sram_cen_o, sram_wen_o  out  1 each  SRAM chip/write enable, low-active.
REQ-013 stall_o  out  1  combinational; 1 = upstream EX/MEM holds its outputs.
REQ-014 wb_valid_o, RegWrite_o, VRegWrite_o, MemtoReg_o  out  1 each  registered MEM/WB controls.
REQ-015 write_addr_o  out  5; alu_result_o  out  32; mem_data_o  out  32; vmem_data_o  out  256  registered MEM/WB data.

Function
REQ-016 States: IDLE, SLD, VST, VLD, VLDL; 3-bit lane counter lane.
REQ-017 SRAM outputs driven combinationally from state, lane and held inputs; sram_cen_o=1 whenever no access is issued.
REQ-018 Inputs stay stable while stall_o=1; the upstream stage advances on the edge where stall_o=0.
REQ-019 IDLE, valid_i=0 or no strobe: no access, stall_o=0, outputs registered next edge (latency 1).
REQ-020 IDLE, scalar store (MemWrite_i=0): cen=0, wen=0, addr=alu_result_i[13:2], d=write_data_i, stall_o=0, stays IDLE.
REQ-021 IDLE, scalar load: cen=0, wen=1, stall_o=1, ->SLD; SLD: mem_data_o<=sram_q_i, stall_o=0, ->IDLE.
REQ-022 IDLE, vector store: ->VST; VST issues writes lane 0..7 on consecutive cycles, addr=base+lane, d=vec_i lane; stall_o=1 except lane 7; ->IDLE after lane 7.
REQ-023 IDLE, vector load: ->VLD; VLD issues reads lane 0..7, captures sram_q_i into lane-1 of vmem_data_o; after lane 7 ->VLDL; VLDL captures lane 7, stall_o=0, ->IDLE.
REQ-024 Vector address base+lane wraps modulo 4096.
REQ-025 Both strobes low: store executes, read ignored.
REQ-026 wb_valid_o/RegWrite_o/VRegWrite_o pulse exactly 1 cycle after the final cycle of each instruction; forced 0 for bubbles and during multi-cycle ops.
REQ-027 Latencies (accept to wb_valid_o): non-mem/store 1, scalar load 2, vector store 8, vector load 9.

Reset
REQ-028 rst_n=0: state=IDLE, lane=0, all outputs 0 except sram_cen_o=1, sram_wen_o=1.
REQ-029 Reset mid-operation aborts immediately; no SRAM access in the cycle after reset; no partial writeback.

Configuration
REQ-030 MEM_STALL_CNT_EN defined: adds output stall_cnt_o [15:0], counts cycles with stall_o=1, saturates at 16'hFFFF, reset 0.
REQ-031 MEM_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 Scalar load alu_result_i=32'h10, SRAM[4]=32'hDEADBEEF -> one stall cycle, mem_data_o=32'hDEADBEEF, wb_valid_o 2 cycles after accept.
REQ-033 Vector store base word 12'hFFE, lanes 1..8 -> writes at FFE,FFF,000..005, stall_o high 7 cycles.
REQ-034 Vector load base 0 of SRAM[k]=k+100 -> vmem_data_o lane k=k+100, wb_valid_o 9 cycles after accept.
REQ-035 Back-to-back ALU op, store, bubble -> wb_valid_o 1,1,0, RegWrite_o forwarded, no stall.
REQ-036 rst_n low at vector-load lane 3 -> next cycle cen=1, state IDLE, no wb_valid_o pulse.
REQ-037 MEM_STALL_CNT_EN: two vector loads -> stall_cnt_o=16.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a single-port SRAM for scalar and 8-lane vector accesses.
// Define MEM_STALL_CNT_EN to add the saturating stall_cnt_o stall-cycle counter.
module mem_access_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic         RegWrite_i,
  input  logic         VRegWrite_i,
  input  logic         MemtoReg_i,
  input  logic         MemRead_i,
  input  logic         MemWrite_i,
  input  logic         vec_mem_i,
  input  logic [31:0]  alu_result_i,
  input  logic [4:0]   write_addr_i,
  input  logic [31:0]  write_data_i,
  input  logic [255:0] vec_i,
  input  logic [31:0]  sram_q_i,
  output logic [11:0]  sram_addr_o,
  output logic [31:0]  sram_d_o,
  output logic         sram_cen_o,
  output logic         sram_wen_o,
  output logic         stall_o,
  output logic         wb_valid_o,
  output logic         RegWrite_o,
  output logic         VRegWrite_o,
  output logic         MemtoReg_o,
  output logic [4:0]   write_addr_o,
  output logic [31:0]  alu_result_o,
  output logic [31:0]  mem_data_o,
`ifdef MEM_STALL_CNT_EN
  output logic [15:0]  stall_cnt_o,
`endif
  output logic [255:0] vmem_data_o
);
  typedef enum logic [2:0] {IDLE, SLD, VST, VLD, VLDL} state_t;
  state_t state, state_nx;
  logic [2:0] lane, lane_nx;
  logic st, ld, acc, wr, stall_raw, go, do_wr;
  always_comb begin
    st = valid_i && !MemWrite_i;
    ld = valid_i && MemWrite_i && !MemRead_i;
    state_nx = state;
    lane_nx = lane;
    acc = 1'b0;
    wr = 1'b0;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        // lane 0 of a vector op is issued here so the burst ends on lane 7
        acc = st || ld;
        wr = st;
        stall_raw = ld || (st && vec_mem_i);
        state_nx = st ? (vec_mem_i ? VST : IDLE) : ld ? (vec_mem_i ? VLD : SLD) : IDLE;
        lane_nx = (vec_mem_i && (st || ld)) ? 3'd1 : 3'd0;
      end
      SLD: state_nx = IDLE;
      VST: begin
        acc = 1'b1;
        wr = 1'b1;
        stall_raw = lane != 3'd7;
        state_nx = lane == 3'd7 ? IDLE : VST;
        lane_nx = lane + 3'd1;
      end
      VLD: begin
        acc = 1'b1;
        stall_raw = 1'b1;
        state_nx = lane == 3'd7 ? VLDL : VLD;
        lane_nx = lane + 3'd1;
      end
      VLDL: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign go = acc && rst_n;
  assign do_wr = go && wr;
  assign stall_o = stall_raw && rst_n;
  assign sram_cen_o = !go;
  assign sram_wen_o = !do_wr;
  assign sram_addr_o = go ? alu_result_i[13:2] + {9'd0, lane} : 12'd0;
  assign sram_d_o = do_wr ? (vec_mem_i ? vec_i[{lane, 5'd0} +: 32] : write_data_i) : 32'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lane <= 3'd0;
      wb_valid_o <= 1'b0;
      RegWrite_o <= 1'b0;
      VRegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      write_addr_o <= 5'd0;
      alu_result_o <= 32'd0;
      mem_data_o <= 32'd0;
      vmem_data_o <= 256'd0;
    end else begin
      state <= state_nx;
      lane <= lane_nx;
      wb_valid_o <= valid_i && !stall_o;
      RegWrite_o <= valid_i && !stall_o && RegWrite_i;
      VRegWrite_o <= valid_i && !stall_o && VRegWrite_i;
      if (!stall_o) begin
        MemtoReg_o <= MemtoReg_i;
        write_addr_o <= write_addr_i;
        alu_result_o <= alu_result_i;
      end
      if (state == SLD) mem_data_o <= sram_q_i;
      // read data trails its issue by one cycle, so it belongs to lane-1 (VLDL wraps to 7)
      if (state == VLD || state == VLDL) vmem_data_o[{lane - 3'd1, 5'd0} +: 32] <= sram_q_i;
    end
  end
`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_o <= 16'd0;
    else if (stall_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random checks of mem_access_stage against an SRAM model and a word-level reference memory.
module tb_mem_access_stage;
  logic clk = 0, rst_n = 0, valid_i = 0, RegWrite_i = 0, VRegWrite_i = 0, MemtoReg_i = 0;
  logic MemRead_i = 1, MemWrite_i = 1, vec_mem_i = 0;
  logic [31:0] alu_result_i = 0, write_data_i = 0, sram_q_i;
  logic [4:0] write_addr_i = 0;
  logic [255:0] vec_i = 0;
  logic [11:0] sram_addr_o;
  logic [31:0] sram_d_o, alu_result_o, mem_data_o;
  logic sram_cen_o, sram_wen_o, stall_o, wb_valid_o, RegWrite_o, VRegWrite_o, MemtoReg_o;
  logic [4:0] write_addr_o;
  logic [255:0] vmem_data_o;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] cnt0;
`endif
  logic [31:0] sram [4096];
  logic [31:0] ref_mem [4096];
  int tests = 0, fails = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i), .VRegWrite_i(VRegWrite_i),
    .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .vec_mem_i(vec_mem_i),
    .alu_result_i(alu_result_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i), .vec_i(vec_i),
    .sram_q_i(sram_q_i), .sram_addr_o(sram_addr_o), .sram_d_o(sram_d_o), .sram_cen_o(sram_cen_o),
    .sram_wen_o(sram_wen_o), .stall_o(stall_o), .wb_valid_o(wb_valid_o), .RegWrite_o(RegWrite_o),
    .VRegWrite_o(VRegWrite_o), .MemtoReg_o(MemtoReg_o), .write_addr_o(write_addr_o),
    .alu_result_o(alu_result_o), .mem_data_o(mem_data_o),
`ifdef MEM_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .vmem_data_o(vmem_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_cen_o) begin
      if (!sram_wen_o) sram[sram_addr_o] = sram_d_o;
      else sram_q_i <= sram[sram_addr_o];
    end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kinds: 0 alu, 1 bubble, 2 scalar store, 3 scalar load, 4 vector store, 5 vector load
  task automatic drive(input int kind, input logic [31:0] alu, input logic both);
    valid_i = kind != 1;
    MemWrite_i = kind == 1 ? 1'($urandom_range(0, 1)) : !(kind == 2 || kind == 4);
    MemRead_i = kind == 1 ? 1'($urandom_range(0, 1)) : !(kind == 3 || kind == 5 || ((kind == 2 || kind == 4) && both));
    vec_mem_i = kind >= 4 ? 1'b1 : kind < 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    RegWrite_i = 1'($urandom_range(0, 1));
    VRegWrite_i = 1'($urandom_range(0, 1));
    MemtoReg_i = 1'($urandom_range(0, 1));
    write_addr_i = 5'($urandom);
    alu_result_i = alu;
    write_data_i = $urandom;
    for (int k = 0; k < 8; k++) vec_i[k*32 +: 32] = $urandom;
  endtask

  task automatic run(input int kind);
    int n, stalls, early, lat, b;
    logic s, ev, erw, evrw, emtr;
    logic [4:0] ewa;
    logic [31:0] ealu, emd;
    logic [255:0] evm;
    lat = kind <= 2 ? 1 : kind == 3 ? 2 : kind == 4 ? 8 : 9;
    b = int'(alu_result_i[13:2]);
    ev = valid_i; erw = valid_i && RegWrite_i; evrw = valid_i && VRegWrite_i;
    emtr = MemtoReg_i; ewa = write_addr_i; ealu = alu_result_i;
    if (kind == 2) ref_mem[b] = write_data_i;
    for (int k = 0; k < 8; k++) begin
      if (kind == 4) ref_mem[(b + k) % 4096] = vec_i[k*32 +: 32];
      evm[k*32 +: 32] = ref_mem[(b + k) % 4096];
    end
    emd = ref_mem[b];
    n = 0; stalls = 0; early = 0;
    do begin
      @(negedge clk);
      s = stall_o;
      stalls += int'(s);
      @(posedge clk);
      #1;
      n++;
      if (s && wb_valid_o) early++;
    end while (s && n < 20);
    valid_i = 0;
    chk("latency", 256'(n), 256'(lat));
    chk("stall_cycles", 256'(stalls), 256'(lat - 1));
    chk("early_wb", 256'(early), 0);
    chk("wb_valid", wb_valid_o, ev);
    chk("RegWrite", RegWrite_o, erw);
    chk("VRegWrite", VRegWrite_o, evrw);
    if (ev) begin
      chk("MemtoReg", MemtoReg_o, emtr);
      chk("write_addr", write_addr_o, ewa);
      chk("alu_result", alu_result_o, ealu);
    end
    if (kind == 3) chk("mem_data", mem_data_o, emd);
    if (kind == 5) chk("vmem_data", vmem_data_o, evm);
    @(posedge clk);
    #1;
    chk("wb_pulse", wb_valid_o, 0);
  endtask

  initial begin
    int mism, kind;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cen", sram_cen_o, 1);
    chk("rst_wen", sram_wen_o, 1);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_vmem", vmem_data_o, 0);
`ifdef MEM_STALL_CNT_EN
    chk("rst_cnt", stall_cnt_o, 0);
`endif
    rst_n = 1;
    sram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    drive(3, 32'h10, 0);
    run(3);
    chk("sld_deadbeef", mem_data_o, 32'hDEADBEEF);
    drive(4, 32'h3FF8, 0);
    for (int k = 0; k < 8; k++) vec_i[k*32 +: 32] = 32'(k + 1);
    run(4);
    chk("vst_ffe", sram[12'hFFE], 1);
    chk("vst_000", sram[12'h000], 3);
    chk("vst_005", sram[12'h005], 8);
    for (int k = 0; k < 8; k++) begin
      sram[k] = 32'(k + 100);
      ref_mem[k] = 32'(k + 100);
    end
`ifdef MEM_STALL_CNT_EN
    cnt0 = stall_cnt_o;
`endif
    drive(5, 32'h0, 0);
    run(5);
    chk("vld_lane3", vmem_data_o[96 +: 32], 103);
    chk("vld_lane7", vmem_data_o[224 +: 32], 107);
    drive(5, 32'h0, 0);
    run(5);
`ifdef MEM_STALL_CNT_EN
    chk("stall_cnt", 256'(stall_cnt_o - cnt0), 16);
`endif
    drive(0, 32'h1234, 0);
    RegWrite_i = 1;
    write_addr_i = 5'd7;
    @(negedge clk);
    chk("b2b_stall0", stall_o, 0);
    @(posedge clk);
    #1;
    chk("b2b_wb0", wb_valid_o, 1);
    chk("b2b_rw0", RegWrite_o, 1);
    chk("b2b_alu0", alu_result_o, 32'h1234);
    drive(2, 32'h40, 0);
    RegWrite_i = 0;
    ref_mem[16] = write_data_i;
    @(negedge clk);
    chk("b2b_stall1", stall_o, 0);
    @(posedge clk);
    #1;
    chk("b2b_wb1", wb_valid_o, 1);
    chk("b2b_rw1", RegWrite_o, 0);
    drive(1, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("b2b_wb2", wb_valid_o, 0);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      drive(kind, $urandom, 1'($urandom_range(0, 1)));
      run(kind);
    end
    drive(5, $urandom, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("vld_mid_stall", stall_o, 1);
    rst_n = 0;
    valid_i = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("abort_cen", sram_cen_o, 1);
    chk("abort_wb", wb_valid_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_vmem", vmem_data_o, 0);
    @(posedge clk);
    #1;
    chk("abort_wb_next", wb_valid_o, 0);
    chk("abort_cen_next", sram_cen_o, 1);
    drive(3, 32'h10, 0);
    run(3);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (sram[i] !== ref_mem[i]) mism++;
    chk("mem_final", 256'(mism), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
